// File: rtl/dmem_access_unit_pkg.sv
// Shared RV32I word/funct3 types and data-memory access-unit types.
// rv32i_types is shared with the rest of the pipeline; dmem_types is local to the MEM stage.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

endpackage

package dmem_types;
  import rv32i_types::*;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } dmem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } access_size_t;

  localparam logic [3:0] MBE_B = 4'b0001;
  localparam logic [3:0] MBE_H = 4'b0011;
  localparam logic [3:0] MBE_W = 4'b1111;

  // Undefined funct3 encodings fall through to word width.
  function automatic access_size_t access_size(input logic is_store, input logic [2:0] f3);
    access_size_t sz;
    sz = SZ_W;
    if (is_store) begin
      case (store_funct3_t'(f3))
        SB:      sz = SZ_B;
        SH:      sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (load_funct3_t'(f3))
        LB, LBU: sz = SZ_B;
        LH, LHU: sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dmem_access_unit_load_formatter.sv
// Combinational load-data formatter: lane select plus sign/zero extension.
module load_formatter
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (load_funct3_t'(funct3))
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result = {24'h0, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LHU:     result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: held-request cache handshake, store lane
// steering, load formatting and pipeline stall. MISALIGN_TRAP_EN enables misalignment flagging.
module dmem_access_unit
  import rv32i_types::*;
  import dmem_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exmem_valid,
  input  logic        exmem_mem_read,
  input  logic        exmem_mem_write,
  input  logic [2:0]  exmem_funct3,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] exmem_rs2_out,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_misaligned
);

  dmem_state_t  state_q, state_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [31:0]  addr_q, addr_d;
  logic [1:0]   addr_lo_q, addr_lo_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   mbe_q, mbe_d;
  logic [31:0]  rdata_hold_q, rdata_hold_d;

  logic         mem_op;
  logic         misaligned;
  logic         pending;
  access_size_t st_size;
  logic [3:0]   st_mbe;
  logic [31:0]  st_wdata;
  logic [31:0]  fmt_result;

  assign mem_op  = exmem_valid & (exmem_mem_read | exmem_mem_write);
  assign st_size = access_size(1'b1, exmem_funct3);

`ifdef MISALIGN_TRAP_EN
  access_size_t ld_size;
  logic         ld_bad, st_bad;

  always_comb begin
    ld_size = access_size(1'b0, exmem_funct3);
    ld_bad  = ((ld_size == SZ_H) & exmem_alu_out[0]) |
              ((ld_size == SZ_W) & (exmem_alu_out[1:0] != 2'b00));
    st_bad  = ((st_size == SZ_H) & exmem_alu_out[0]) |
              ((st_size == SZ_W) & (exmem_alu_out[1:0] != 2'b00));
    misaligned = (exmem_mem_read & ld_bad) | (exmem_mem_write & st_bad);
  end
`else
  assign misaligned = 1'b0;
`endif

  assign pending = mem_op & ~misaligned;

  // Halfword lane comes from addr[1] only, so addr[0] is ignored when traps are off.
  always_comb begin
    st_mbe   = '0;
    st_wdata = exmem_rs2_out;
    case (st_size)
      SZ_B: begin
        st_mbe   = MBE_B << exmem_alu_out[1:0];
        st_wdata = exmem_rs2_out << {exmem_alu_out[1:0], 3'b000};
      end
      SZ_H: begin
        st_mbe   = MBE_H << {exmem_alu_out[1], 1'b0};
        st_wdata = exmem_rs2_out << {exmem_alu_out[1], 4'b0000};
      end
      default: begin
        st_mbe   = MBE_W;
        st_wdata = exmem_rs2_out;
      end
    endcase
    if (!exmem_mem_write) st_mbe = '0;
  end

  load_formatter u_load_formatter (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .rdata   (dmem_rdata),
    .result  (fmt_result)
  );

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    mbe_d        = mbe_q;
    rdata_hold_d = rdata_hold_q;
    case (state_q)
      IDLE: begin
        if (pending) begin
          state_d   = ACCESS;
          rd_d      = exmem_mem_read;
          wr_d      = exmem_mem_write;
          addr_d    = {exmem_alu_out[31:2], 2'b00};
          addr_lo_d = exmem_alu_out[1:0];
          funct3_d  = exmem_funct3;
          wdata_d   = st_wdata;
          mbe_d     = st_mbe;
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) rdata_hold_d = fmt_result;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      addr_lo_q    <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      mbe_q        <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      mbe_q        <= mbe_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign dmem_read    = rd_q;
  assign dmem_write   = wr_q;
  assign dmem_address = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_mbe     = mbe_q;
  assign mem_rdata    = rdata_hold_q;

  // Gated by rst so the combinational flags also read 0 while reset is held.
  assign mem_stall      = rst & (((state_q == IDLE) & pending) | (state_q == ACCESS));
  assign mem_misaligned = rst & (state_q == IDLE) & mem_op & misaligned;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: expected request/result pushed at issue, popped at DONE.
module tb_dmem_access_unit;

  logic        clk;
  logic        rst;
  logic        exmem_valid;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_alu_out;
  logic [31:0] exmem_rs2_out;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_misaligned;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int unsigned n_vec;
  int unsigned n_err;
  logic [31:0] hold;

  dmem_access_unit dut (
    .clk             (clk),
    .rst             (rst),
    .exmem_valid     (exmem_valid),
    .exmem_mem_read  (exmem_mem_read),
    .exmem_mem_write (exmem_mem_write),
    .exmem_funct3    (exmem_funct3),
    .exmem_alu_out   (exmem_alu_out),
    .exmem_rs2_out   (exmem_rs2_out),
    .dmem_read       (dmem_read),
    .dmem_write      (dmem_write),
    .dmem_address    (dmem_address),
    .dmem_wdata      (dmem_wdata),
    .dmem_mbe        (dmem_mbe),
    .dmem_rdata      (dmem_rdata),
    .dmem_resp       (dmem_resp),
    .mem_rdata       (mem_rdata),
    .mem_stall       (mem_stall),
    .mem_misaligned  (mem_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] k,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = w >> (32'(k) * 8);
    h = k[1] ? (w >> 16) : w;
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b100:  return {24'h0, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b101:  return {16'h0, h[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           output logic [3:0] mbe, output logic [31:0] wd);
    case (f3)
      3'b000: begin
        mbe = 4'b0001 << a[1:0];
        wd  = d << (32'(a[1:0]) * 8);
      end
      3'b001: begin
        mbe = a[1] ? 4'b1100 : 4'b0011;
        wd  = a[1] ? {d[15:0], 16'h0} : d;
      end
      default: begin
        mbe = 4'b1111;
        wd  = d;
      end
    endcase
  endtask

  task automatic drive_idle();
    exmem_valid     = 1'b0;
    exmem_mem_read  = 1'b0;
    exmem_mem_write = 1'b0;
    exmem_funct3    = 3'b000;
    exmem_alu_out   = '0;
    exmem_rs2_out   = '0;
    dmem_resp       = 1'b0;
  endtask

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] word, input int unsigned lat);
    sb_entry_t e;
    e.addr = {a[31:2], 2'b00};
    if (st) ref_store(f3, a, d, e.mbe, e.wdata);
    else begin
      e.mbe   = 4'b0000;
      e.wdata = '0;
    end
    e.rdata = ld ? ref_load(f3, a[1:0], word) : hold;
    sb.push_back(e);

    @(posedge clk); #1;
    exmem_valid     = 1'b1;
    exmem_mem_read  = ld;
    exmem_mem_write = st;
    exmem_funct3    = f3;
    exmem_alu_out   = a;
    exmem_rs2_out   = d;
    dmem_rdata      = word;
    dmem_resp       = 1'b0;
    #1;
    check_eq("stall_c0", 32'(mem_stall), 32'd1);
    check_eq("req_c0", 32'({dmem_read, dmem_write}), 32'd0);

    for (int unsigned i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      check_eq("stall_acc", 32'(mem_stall), 32'd1);
      check_eq("req_acc", 32'({dmem_read, dmem_write}), 32'({ld, st}));
      if (i == 1) begin
        check_eq("address", dmem_address, sb[0].addr);
        check_eq("mbe", 32'(dmem_mbe), 32'(sb[0].mbe));
        if (st) check_eq("wdata", dmem_wdata, sb[0].wdata);
      end
      if (i == lat) dmem_resp = 1'b1;
    end

    @(posedge clk); #1;
    dmem_resp = 1'b0;
    e = sb.pop_front();
    check_eq("stall_done", 32'(mem_stall), 32'd0);
    check_eq("req_done", 32'({dmem_read, dmem_write}), 32'd0);
    check_eq("mem_rdata", mem_rdata, e.rdata);
    hold = e.rdata;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    hold       = '0;
    dmem_rdata = '0;
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_read", 32'(dmem_read), 32'd0);
    check_eq("rst_write", 32'(dmem_write), 32'd0);
    check_eq("rst_addr", dmem_address, 32'd0);
    check_eq("rst_wdata", dmem_wdata, 32'd0);
    check_eq("rst_mbe", 32'(dmem_mbe), 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'd0);
    check_eq("rst_stall", 32'(mem_stall), 32'd0);
    check_eq("rst_misal", 32'(mem_misaligned), 32'd0);
    rst = 1'b1;

    // Directed loads and stores
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1);
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 2);
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 1);
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h80FF_7F01, 1);
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0, 1);
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_00AB, 32'h0, 2);
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h1234_5678, 32'h0, 1);
    run_op(1'b1, 1'b0, 3'b111, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1);

    // Non-memory instruction with a spurious response
    @(posedge clk); #1;
    drive_idle();
    exmem_valid = 1'b1;
    dmem_resp   = 1'b1;
    #1;
    check_eq("nomem_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    check_eq("nomem_req", 32'({dmem_read, dmem_write}), 32'd0);
    check_eq("nomem_rdata", mem_rdata, hold);
    check_eq("nomem_stall2", 32'(mem_stall), 32'd0);

`ifdef MISALIGN_TRAP_EN
    @(posedge clk); #1;
    drive_idle();
    exmem_valid    = 1'b1;
    exmem_mem_read = 1'b1;
    exmem_funct3   = 3'b010;
    exmem_alu_out  = 32'h0000_0102;
    #1;
    check_eq("misal_flag", 32'(mem_misaligned), 32'd1);
    check_eq("misal_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    check_eq("misal_req", 32'({dmem_read, dmem_write}), 32'd0);
    check_eq("misal_rdata", mem_rdata, hold);
    drive_idle();
`else
    @(posedge clk); #1;
    drive_idle();
    #1;
    check_eq("misal_off", 32'(mem_misaligned), 32'd0);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0BAD_CAFE, 1);
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_0103, 32'hA5A5_5A5A, 32'h0, 1);
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1);
`endif

    // Randomised aligned traffic
    for (int unsigned n = 0; n < 12; n++) begin
      logic        is_ld;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [2:0]  ld_codes [5];
      ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      is_ld = 1'($urandom_range(0, 1));
      f3 = is_ld ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      run_op(is_ld, ~is_ld, f3, a, $urandom, $urandom, $urandom_range(1, 4));
    end

    // Reset asserted while the request is outstanding
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1111_2222, 1);
    @(posedge clk); #1;
    exmem_valid    = 1'b1;
    exmem_mem_read = 1'b1;
    exmem_funct3   = 3'b010;
    exmem_alu_out  = 32'h0000_0500;
    dmem_rdata     = 32'h5555_AAAA;
    @(posedge clk); #1;
    check_eq("mid_req", 32'(dmem_read), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'({dmem_read, dmem_write}), 32'd0);
    check_eq("mid_rst_addr", dmem_address, 32'd0);
    check_eq("mid_rst_stall", 32'(mem_stall), 32'd0);
    check_eq("mid_rst_rdata", mem_rdata, 32'd0);
    hold = '0;
    drive_idle();
    @(posedge clk); #1;
    rst       = 1'b1;
    dmem_resp = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    check_eq("late_resp_req", 32'({dmem_read, dmem_write}), 32'd0);
    check_eq("late_resp_stall", 32'(mem_stall), 32'd0);
    check_eq("late_resp_rdata", mem_rdata, hold);
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0601, 32'h0, 32'h0000_7F00, 1);
    @(posedge clk); #1;
    drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
